fetch_sequencer: RTL and testbench

- Controller for the pipelined fetch stage. Owns the PC and sequences the synchronous instruction memory (enable plus address).
- Applies stall from the hazard unit, redirects from EX, and a halt request.
- Produces the IF/ID pipeline register contents (PC, PC+4, valid) and a one-cycle flush pulse to ID.
- Sits between the hazard/branch logic and the instruction memory, replacing the free-running PC/next-PC path.

---
 rtl/fetch_sequencer_if.sv | 30 +++
 rtl/fetch_sequencer.sv | 103 ++++++++++
 tb/tb_fetch_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: hazard/branch controls in, instruction-memory request and
// IF/ID register contents out.
interface fetch_sequencer_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt;
  logic        imem_ena;
  logic [31:0] imem_addr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus_4;
  logic        ifid_valid;
  logic        flush;
  logic        misalign_err;
  logic [31:0] fetch_count;
  logic [1:0]  state;

  // master drives the control inputs (hazard unit / EX); slave is the sequencer
  modport master (
    output stall, branch_taken, branch_target, halt,
    input  imem_ena, imem_addr, ifid_pc, ifid_pc_plus_4, ifid_valid,
           flush, misalign_err, fetch_count, state
  );

  modport slave (
    input  stall, branch_taken, branch_target, halt,
    output imem_ena, imem_addr, ifid_pc, ifid_pc_plus_4, ifid_valid,
           flush, misalign_err, fetch_count, state
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, drives the synchronous instruction
// memory and produces the IF/ID register contents, flush pulse and status.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // BOOT_CYCLES of 0 and 1 both leave BOOT on the first edge after release
  localparam logic [31:0] BOOT_LAST = (BOOT_CYCLES == 0) ? 32'd0 : 32'(BOOT_CYCLES - 1);

  state_e      r_state;
  logic [31:0] r_boot_cnt;
  logic [31:0] r_pc;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_pc_plus_4;
  logic        r_ifid_valid;
  logic        r_flush;
  logic        r_misalign_err;
  logic [31:0] r_fetch_count;

  logic        w_fetch;
  logic [31:0] w_pc_plus_4;
  logic [31:0] w_target;
  logic        w_target_misaligned;

  // A taken branch overrides halt, so the wrong-path fetch still goes out
  assign w_fetch             = (r_state == ST_RUN) & ~bus.stall
                               & ~(bus.halt & ~bus.branch_taken);
  assign w_pc_plus_4         = r_pc + 32'd4;
  assign w_target            = {bus.branch_target[31:2], 2'b00};
  assign w_target_misaligned = |bus.branch_target[1:0];

  assign bus.imem_ena       = w_fetch;
  assign bus.imem_addr      = r_pc;
  assign bus.ifid_pc        = r_ifid_pc;
  assign bus.ifid_pc_plus_4 = r_ifid_pc_plus_4;
  assign bus.ifid_valid     = r_ifid_valid;
  assign bus.flush          = r_flush;
  assign bus.misalign_err   = r_misalign_err;
  assign bus.fetch_count    = r_fetch_count;
  assign bus.state          = r_state;

  // NOTE: every register here is updated with <= so all reads in this block
  // see the pre-edge values, matching the one-cycle pipeline semantics.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state          <= ST_BOOT;
      r_boot_cnt       <= 32'd0;
      r_pc             <= RESET_PC;
      r_ifid_pc        <= 32'd0;
      r_ifid_pc_plus_4 <= 32'd4;
      r_ifid_valid     <= 1'b0;
      r_flush          <= 1'b0;
      r_misalign_err   <= 1'b0;
      r_fetch_count    <= 32'd0;
    end else begin
      r_flush <= 1'b0;
      if (w_fetch) r_fetch_count <= r_fetch_count + 32'd1;

      case (r_state)
        ST_BOOT: begin
          if (r_boot_cnt == BOOT_LAST) r_state <= ST_RUN;
          else                         r_boot_cnt <= r_boot_cnt + 32'd1;
        end

        ST_RUN: begin
          if (bus.branch_taken) begin
            // squash the wrong-path fetch even when stalled
            r_pc         <= w_target;
            r_ifid_valid <= 1'b0;
            r_flush      <= 1'b1;
            if (w_target_misaligned) r_misalign_err <= 1'b1;
          end else if (bus.halt) begin
            r_state      <= ST_HALTED;
            r_ifid_valid <= 1'b0;
          end else if (!bus.stall) begin
            r_pc             <= w_pc_plus_4;
            r_ifid_pc        <= r_pc;
            r_ifid_pc_plus_4 <= w_pc_plus_4;
            r_ifid_valid     <= 1'b1;
          end
        end

        ST_HALTED: begin
          if (!bus.stall) r_ifid_valid <= 1'b0;
        end

        default: r_state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios then random
// stimulus, all compared against a cycle-level behavioural model.
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          BOOT_CYCLES = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(RESET_PC), .BOOT_CYCLES(BOOT_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model: mode 0=boot 1=run 2=halted, boot_left counts down
  int          m_mode;
  int          m_boot_left;
  logic [31:0] m_pc, m_ifid_pc, m_ifid_p4, m_cnt;
  logic        m_valid, m_flush, m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_mode      = 0;
    m_boot_left = BOOT_CYCLES;
    m_pc        = RESET_PC;
    m_ifid_pc   = 32'd0;
    m_ifid_p4   = 32'd4;
    m_valid     = 1'b0;
    m_flush     = 1'b0;
    m_mis       = 1'b0;
    m_cnt       = 32'd0;
  endtask

  task automatic model_edge(input logic rst, st, br, input logic [31:0] tgt,
                            input logic hl, input logic fetched);
    if (!rst) begin
      model_reset();
      return;
    end
    m_flush = 1'b0;
    if (fetched) m_cnt = m_cnt + 1;
    if (m_mode == 0) begin
      if (m_boot_left <= 1) m_mode = 1;
      else m_boot_left = m_boot_left - 1;
    end else if (m_mode == 1) begin
      if (br) begin
        m_pc    = tgt & 32'hFFFF_FFFC;
        m_valid = 1'b0;
        m_flush = 1'b1;
        if (tgt % 4 != 0) m_mis = 1'b1;
      end else if (hl) begin
        m_mode  = 2;
        m_valid = 1'b0;
      end else if (!st) begin
        m_ifid_pc = m_pc;
        m_ifid_p4 = m_pc + 4;
        m_pc      = m_pc + 4;
        m_valid   = 1'b1;
      end
    end else begin
      if (!st) m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic rst, st, br, input logic [31:0] tgt, input logic hl);
    logic exp_ena;
    reset             = rst;
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.halt          = hl;
    #1;
    exp_ena = (m_mode == 1) && !st && !(hl && !br);
    chk("imem_ena", bus.imem_ena, exp_ena);
    chk("imem_addr", bus.imem_addr, m_pc);
    @(posedge clk);
    model_edge(rst, st, br, tgt, hl, exp_ena);
    #1;
    chk("ifid_pc", bus.ifid_pc, m_ifid_pc);
    chk("ifid_pc_plus_4", bus.ifid_pc_plus_4, m_ifid_p4);
    chk("ifid_valid", bus.ifid_valid, m_valid);
    chk("flush", bus.flush, m_flush);
    chk("misalign_err", bus.misalign_err, m_mis);
    chk("fetch_count", bus.fetch_count, m_cnt);
    chk("state", bus.state, m_mode);
    chk("imem_addr_post", bus.imem_addr, m_pc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  logic [31:0] saved_cnt;

  initial begin
    reset = 1'b0;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'd0; bus.halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // reset, boot, first fetches
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    idle(2);
    chk("boot_no_fetch", bus.fetch_count, 32'd0);
    idle(3);
    chk("fetch_count_3", bus.fetch_count, 32'd3);
    chk("ifid_pc_lag", bus.ifid_pc, 32'h8);
    idle(1);

    // stall while pc=0x10
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("stall_pc", bus.imem_addr, 32'h10);
    chk("stall_ifid_pc", bus.ifid_pc, 32'hC);
    chk("stall_valid", bus.ifid_valid, 1'b1);
    idle(4);
    chk("pc_0x20", bus.imem_addr, 32'h20);

    // taken branch to 0x100
    step(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
    chk("br_flush", bus.flush, 1'b1);
    chk("br_valid", bus.ifid_valid, 1'b0);
    chk("br_addr", bus.imem_addr, 32'h100);
    idle(1);
    chk("br_ifid_pc", bus.ifid_pc, 32'h100);
    chk("br_flush_clear", bus.flush, 1'b0);

    // branch + stall, misaligned target
    step(1'b1, 1'b1, 1'b1, 32'h202, 1'b0);
    chk("mis_addr", bus.imem_addr, 32'h200);
    chk("mis_err", bus.misalign_err, 1'b1);
    idle(1);
    chk("mis_sticky", bus.misalign_err, 1'b1);
    chk("mis_flush_1cyc", bus.flush, 1'b0);

    // halt at pc=0x40
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    idle(2 + 16);
    chk("pc_0x40", bus.imem_addr, 32'h40);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("halted_state", bus.state, 2'd2);
    saved_cnt = bus.fetch_count;
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
    chk("halted_no_fetch", bus.fetch_count, saved_cnt);
    chk("halted_stays", bus.state, 2'd2);

    // halt together with branch: branch wins
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 1'b1, 32'h80, 1'b1);
    chk("halt_br_state", bus.state, 2'd1);
    chk("halt_br_addr", bus.imem_addr, 32'h80);

    // reset mid-RUN at pc=0x80
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("rst_state", bus.state, 2'd0);
    chk("rst_pc", bus.imem_addr, RESET_PC);
    chk("rst_cnt", bus.fetch_count, 32'd0);
    chk("rst_p4", bus.ifid_pc_plus_4, 32'd4);

    // PC wrap
    idle(2);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    idle(1);
    chk("wrap_pc", bus.imem_addr, 32'h0);
    chk("wrap_ifid_pc", bus.ifid_pc, 32'hFFFF_FFFC);
    chk("wrap_p4", bus.ifid_pc_plus_4, 32'h0);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = $urandom;
      if ($urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
      step($urandom_range(0, 63) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, tgt, $urandom_range(0, 24) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
